fft_bf_sequencer: RTL and testbench
===================================

FFT_BF_SEQUENCER -- requirements
Module: fft_bf_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, sample/twiddle word width in IEEE-754 single format.
REQ-002 Parameter N, default 8, FFT length; legal values are powers of two from 4 to 64; LOG2N = log2(N).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  / in_ready  output  1  / in_data  input  DATA_W: sample load stream, natural order.
REQ-006 out_valid  output  1  / out_ready  input  1  / out_data  output  DATA_W: result stream, natural index order.
REQ-007 bf_a, bf_b, bf_w  output  DATA_W  each: operands to the downstream butterfly (A, B, twiddle).
REQ-008 bf_plus, bf_minus  input  DATA_W  each: combinational butterfly results for the presented operands.
REQ-009 busy  output  1  high in COMPUTE and UNLOAD states.

Function
REQ-010 Internal buffer SHALL hold N words; butterflies SHALL update it in place.
REQ-011 FSM states SHALL be LOAD, ISSUE, WRITE, UNLOAD; reset state is LOAD.
REQ-012 LOAD: in_ready=1; each in_valid&&in_ready beat SHALL write in_data to buf[bitrev(k)], where k is the load count 0..N-1.
REQ-013 The beat with k=N-1 SHALL move the FSM to ISSUE with stage s=0 and butterfly index j=0.
REQ-014 Addressing SHALL be: half=2^s; pos=j mod half; a_idx=(j/half)*2*half+pos; b_idx=a_idx+half; tw_idx=pos*(N/(2*half)).
REQ-015 ISSUE SHALL register bf_a=buf[a_idx], bf_b=buf[b_idx], bf_w=TW_ROM[tw_idx], then go to WRITE.
REQ-016 WRITE SHALL write buf[a_idx]=bf_plus and buf[b_idx]=bf_minus while operands are held stable.
REQ-017 WRITE SHALL then advance j; at j=N/2-1 it SHALL reset j to 0 and increment s.
REQ-018 After WRITE with s=LOG2N-1 and j=N/2-1, the FSM SHALL go to UNLOAD.
REQ-019 Compute latency SHALL be exactly N*LOG2N cycles (24 for N=8) from the last load beat to the first out_valid.
REQ-020 UNLOAD: out_valid=1, out_data=buf[m] for m=0..N-1; m SHALL advance only on out_valid&&out_ready.
REQ-021 Under out_ready=0, out_data and out_valid SHALL hold; the beat m=N-1 SHALL return the FSM to LOAD.
REQ-022 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored with no buffer write.
REQ-023 bf_a/bf_b/bf_w SHALL hold their last values outside ISSUE/WRITE.

Reset
REQ-024 On rst_n=0, at any point including mid-compute or mid-unload: FSM=LOAD, k=m=s=j=0.
REQ-025 Reset values SHALL be out_valid=0, busy=0, bf_a=bf_b=bf_w=0, out_data=0, in_ready=1 after release.
REQ-026 Buffer contents need not be reset; every entry SHALL be rewritten by LOAD before use.

Structure
REQ-027 Shared package fft_pkg SHALL hold DATA_W, N, LOG2N, the state enum, and TW_ROM (N/2 entries, real part of e^(-j2*pi*k/N)).
REQ-028 For N=8, TW_ROM SHALL be 0x3F800000, 0x3F3504F3, 0x00000000, 0xBF3504F3.
REQ-029 Sub-module fft_addr_gen SHALL compute a_idx, b_idx, tw_idx combinationally from s and j.
REQ-030 Butterfly arithmetic SHALL stay outside this block.

Verification (bench uses an integer stub butterfly: plus=A+B, minus=A-B, W recorded)
REQ-031 Load 0..7 -> after 24 cycles out_data sequence SHALL be 28, 0xFFFFFFF0, 0xFFFFFFF8, 0, 0xFFFFFFFC, 0, 0, 0.
REQ-032 Recorded bf_w index sequence SHALL be 0,0,0,0 / 0,2,0,2 / 0,1,2,3, matching the REQ-028 words.
REQ-033 out_ready toggled 1-0-0-1 during UNLOAD -> no dropped or duplicated word, and out_data stable while stalled.
REQ-034 in_valid=1 held through COMPUTE -> in_ready=0 and buffer unchanged, so results still match REQ-031.
REQ-035 rst_n pulsed low at compute cycle 10, then 0..7 reloaded -> state=LOAD, busy=0, and REQ-031 result reproduced.
REQ-036 Two back-to-back frames (0..7, then all 1) -> second output is 8,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT sequencer types and constants: geometry, FSM states, twiddle ROM builder.
// The twiddle table is built at elaboration time from the real cosine.
package fft_pkg;
  localparam int DATA_W = 32;
  localparam int N      = 8;
  localparam int LOG2N  = $clog2(N);
  localparam int TW_MAX = 32;
  localparam real PI    = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_WRITE,
    ST_UNLOAD
  } state_t;

  // Round-to-nearest-even double -> single; tiny residues such as cos(pi/2) snap to +0.
  function automatic logic [31:0] real_to_single(input real x);
    logic [63:0] d;
    logic [30:0] mag;
    int          e;
    d = $realtobits(x);
    if (x > -1.0e-9 && x < 1.0e-9) return 32'h0;
    e   = int'(d[62:52]) - 896;
    mag = {e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [TW_MAX*32-1:0] tw_rom_init(input int n);
    logic [TW_MAX*32-1:0] t;
    t = '0;
    for (int k = 0; k < n / 2; k++)
      t[k*32 +: 32] = real_to_single($cos(2.0 * PI * real'(k) / real'(n)));
    return t;
  endfunction

  localparam logic [TW_MAX*32-1:0] TW_ROM = tw_rom_init(N);

  function automatic int bitrev(input int k, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place butterfly addressing from stage s and butterfly index j.
// Purely combinational, no handshake.
module fft_addr_gen #(
  parameter int N     = 8,
  parameter int LOG2N = $clog2(N),
  parameter int SW    = $clog2(LOG2N),
  parameter int JW    = LOG2N - 1
) (
  input  logic [SW-1:0]    s,
  input  logic [JW-1:0]    j,
  output logic [LOG2N-1:0] a_idx,
  output logic [LOG2N-1:0] b_idx,
  output logic [LOG2N-1:0] tw_idx
);
  logic [LOG2N-1:0] jx;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;

  always_comb begin
    jx     = LOG2N'(j);
    half   = LOG2N'(1) << s;
    pos    = jx & (half - LOG2N'(1));
    a_idx  = ((jx >> s) << (int'(s) + 1)) | pos;
    b_idx  = a_idx | half;
    tw_idx = pos << (LOG2N - 1 - int'(s));
  end
endmodule

// File: rtl/fft_bf_sequencer.sv
// In-place radix-2 FFT sequencer: bit-reversed load, ISSUE/WRITE per butterfly, natural-order unload.
// First out_valid N*LOG2N cycles after the last load beat; unload holds data under out_ready=0.
module fft_bf_sequencer import fft_pkg::*; #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N      = fft_pkg::N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] bf_a,
  output logic [DATA_W-1:0] bf_b,
  output logic [DATA_W-1:0] bf_w,
  input  logic [DATA_W-1:0] bf_plus,
  input  logic [DATA_W-1:0] bf_minus,
  output logic              busy
);
  localparam int LOG2N = $clog2(N);
  localparam int SW    = $clog2(LOG2N);
  localparam int JW    = LOG2N - 1;
  localparam logic [TW_MAX*32-1:0] TW_TABLE = tw_rom_init(N);

  state_t            state;
  logic [LOG2N-1:0]  k;
  logic [LOG2N-1:0]  m;
  logic [SW-1:0]     s;
  logic [JW-1:0]     j;
  logic [LOG2N-1:0]  a_idx;
  logic [LOG2N-1:0]  b_idx;
  logic [LOG2N-1:0]  tw_idx;
  logic [LOG2N-1:0]  load_idx;
  logic [31:0]       tw_word;
  logic [DATA_W-1:0] sbuf [N];

  fft_addr_gen #(.N(N), .LOG2N(LOG2N), .SW(SW), .JW(JW)) u_addr (
    .s      (s),
    .j      (j),
    .a_idx  (a_idx),
    .b_idx  (b_idx),
    .tw_idx (tw_idx)
  );

  assign load_idx = LOG2N'(bitrev(int'(k), LOG2N));
  assign tw_word  = TW_TABLE[int'(tw_idx)*32 +: 32];

  // Sample buffer carries no reset: LOAD rewrites every entry before compute reads it.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && in_valid) begin
      sbuf[load_idx] <= in_data;
    end else if (state == ST_WRITE) begin
      sbuf[a_idx] <= bf_plus;
      sbuf[b_idx] <= bf_minus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      k         <= '0;
      m         <= '0;
      s         <= '0;
      j         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      bf_a      <= '0;
      bf_b      <= '0;
      bf_w      <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (k == LOG2N'(N - 1)) begin
              k        <= '0;
              s        <= '0;
              j        <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_ISSUE;
            end else begin
              k <= k + LOG2N'(1);
            end
          end
        end
        ST_ISSUE: begin
          bf_a  <= sbuf[a_idx];
          bf_b  <= sbuf[b_idx];
          bf_w  <= DATA_W'(tw_word);
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_ISSUE;
          if (j == JW'(N / 2 - 1)) begin
            j <= '0;
            if (s == SW'(LOG2N - 1)) begin
              s         <= '0;
              out_valid <= 1'b1;
              // Entry 0 is never touched by the final butterfly, so it is already settled.
              out_data  <= sbuf[0];
              state     <= ST_UNLOAD;
            end else begin
              s <= s + SW'(1);
            end
          end else begin
            j <= j + JW'(1);
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (m == LOG2N'(N - 1)) begin
              m         <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              m        <= m + LOG2N'(1);
              out_data <= sbuf[m + LOG2N'(1)];
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Directed bench for fft_bf_sequencer with an integer stub butterfly (plus=A+B, minus=A-B).
module tb_fft_bf_sequencer;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] bf_a, bf_b, bf_w, bf_plus, bf_minus;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] got [8];
  int          n_got;
  int          stall_bad;
  logic [31:0] tw_seen [12];
  int          lat;
  int          rdy_high;

  logic [31:0] exp_ramp [8] = '{32'd28, 32'hFFFFFFF0, 32'hFFFFFFF8, 32'd0,
                                32'hFFFFFFFC, 32'd0, 32'd0, 32'd0};
  logic [31:0] exp_ones [8] = '{32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  int          exp_tw_idx [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  logic [31:0] tw_words [4] = '{32'h3F800000, 32'h3F3504F3, 32'h00000000, 32'hBF3504F3};

  always #5 clk = ~clk;

  assign bf_plus  = bf_a + bf_b;
  assign bf_minus = bf_a - bf_b;

  fft_bf_sequencer #(.DATA_W(32), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bf_a      (bf_a),
    .bf_b      (bf_b),
    .bf_w      (bf_w),
    .bf_plus   (bf_plus),
    .bf_minus  (bf_minus),
    .busy      (busy)
  );

  task automatic load_frame(input logic [31:0] base, input logic [31:0] step, input bit hold);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = base + step * i;
      @(posedge clk); #1;
    end
    if (hold) in_data = 32'hDEADBEEF;
    else in_valid = 1'b0;
  endtask

  task automatic wait_result();
    lat = 0;
    rdy_high = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if ((lat % 2) == 1 && lat <= 23) tw_seen[lat/2] = bf_w;
      if (in_ready) rdy_high++;
    end
  endtask

  task automatic unload(input logic [3:0] pat);
    int          cyc;
    bit          prev_stall;
    logic [31:0] prev_data;
    n_got = 0;
    stall_bad = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (n_got < 8 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      if (out_valid && out_ready) begin
        got[n_got] = out_data;
        n_got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b want=0", out_valid); n_fail++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); n_fail++; end
    n_cmp++; if (bf_a !== 32'd0) begin $display("FAIL reset_bf_a got=%h want=0", bf_a); n_fail++; end
    n_cmp++; if (bf_b !== 32'd0) begin $display("FAIL reset_bf_b got=%h want=0", bf_b); n_fail++; end
    n_cmp++; if (bf_w !== 32'd0) begin $display("FAIL reset_bf_w got=%h want=0", bf_w); n_fail++; end
    n_cmp++; if (out_data !== 32'd0) begin $display("FAIL reset_out_data got=%h want=0", out_data); n_fail++; end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b want=1", in_ready); n_fail++; end
    n_cmp++; if (dut.state !== ST_LOAD) begin $display("FAIL reset_state got=%0d want=%0d", dut.state, ST_LOAD); n_fail++; end
  endtask

  task automatic test_basic();
    load_frame(32'd0, 32'd1, 1'b0);
    wait_result();
    n_cmp++; if (lat != 24) begin $display("FAIL basic_latency got=%0d want=24", lat); n_fail++; end
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL basic_busy_unload got=%b want=1", busy); n_fail++; end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (tw_seen[i] !== tw_words[exp_tw_idx[i]]) begin
        $display("FAIL basic_twiddle[%0d] got=%h want=%h", i, tw_seen[i], tw_words[exp_tw_idx[i]]);
        n_fail++;
      end
    end
    unload(4'b1111);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_ramp[i]) begin $display("FAIL basic_out[%0d] got=%h want=%h", i, got[i], exp_ramp[i]); n_fail++; end
    end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL basic_out_valid_after got=%b want=0", out_valid); n_fail++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL basic_busy_after got=%b want=0", busy); n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL basic_in_ready_after got=%b want=1", in_ready); n_fail++; end
  endtask

  task automatic test_stall();
    load_frame(32'd0, 32'd1, 1'b0);
    wait_result();
    unload(4'b1001);
    n_cmp++; if (n_got != 8) begin $display("FAIL stall_count got=%0d want=8", n_got); n_fail++; end
    n_cmp++; if (stall_bad != 0) begin $display("FAIL stall_hold got=%0d unstable want=0", stall_bad); n_fail++; end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_ramp[i]) begin $display("FAIL stall_out[%0d] got=%h want=%h", i, got[i], exp_ramp[i]); n_fail++; end
    end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL stall_no_extra got=%b want=0", out_valid); n_fail++; end
  endtask

  task automatic test_in_valid_hold();
    load_frame(32'd0, 32'd1, 1'b1);
    wait_result();
    in_valid = 1'b0;
    n_cmp++; if (rdy_high != 0) begin $display("FAIL hold_in_ready got=%0d high cycles want=0", rdy_high); n_fail++; end
    n_cmp++; if (lat != 24) begin $display("FAIL hold_latency got=%0d want=24", lat); n_fail++; end
    unload(4'b1111);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_ramp[i]) begin $display("FAIL hold_out[%0d] got=%h want=%h", i, got[i], exp_ramp[i]); n_fail++; end
    end
  endtask

  task automatic test_reset_mid();
    load_frame(32'd0, 32'd1, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (dut.state !== ST_LOAD) begin $display("FAIL midrst_state got=%0d want=%0d", dut.state, ST_LOAD); n_fail++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL midrst_busy got=%b want=0", busy); n_fail++; end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL midrst_out_valid got=%b want=0", out_valid); n_fail++; end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL midrst_in_ready got=%b want=1", in_ready); n_fail++; end
    load_frame(32'd0, 32'd1, 1'b0);
    wait_result();
    n_cmp++; if (lat != 24) begin $display("FAIL midrst_latency got=%0d want=24", lat); n_fail++; end
    unload(4'b1111);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_ramp[i]) begin $display("FAIL midrst_out[%0d] got=%h want=%h", i, got[i], exp_ramp[i]); n_fail++; end
    end
  endtask

  task automatic test_back_to_back();
    load_frame(32'd0, 32'd1, 1'b0);
    wait_result();
    unload(4'b1111);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_ramp[i]) begin $display("FAIL b2b_first[%0d] got=%h want=%h", i, got[i], exp_ramp[i]); n_fail++; end
    end
    load_frame(32'd1, 32'd0, 1'b0);
    wait_result();
    n_cmp++; if (lat != 24) begin $display("FAIL b2b_latency got=%0d want=24", lat); n_fail++; end
    unload(4'b1111);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== exp_ones[i]) begin $display("FAIL b2b_second[%0d] got=%h want=%h", i, got[i], exp_ones[i]); n_fail++; end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_in_valid_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
